// File: rtl/frame_pkg.sv
// Shared types, default sizes and rotation index helpers for the frame tracker
// and the window writer that feeds it.
package frame_pkg;

    localparam int WIN_DEF = 5;
    localparam int CW_DEF  = 3;

    typedef enum logic [1:0] {IDLE, CHECK, BUILD, DONE} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_CW, CMD_CCW, CMD_RSV} cmd_t;

    // Both helpers return the flat row-major index (row*win + col) of the
    // source cell of the unrotated mask that lands on (r, c).
    function automatic int rot_cw_idx(input int win, input int r, input int c);
        return (win - 1 - c) * win + r;
    endfunction

    function automatic int rot_ccw_idx(input int win, input int r, input int c);
        return c * win + (win - 1 - r);
    endfunction

endpackage

// File: rtl/frame_track_if.sv
// Request/result bundle between the window writer (master) and frame_track (slave).
interface frame_track_if import frame_pkg::*; #(
    parameter int WIN = WIN_DEF,
    parameter int CW  = CW_DEF
);
    // Handshake: a start is a frame_ready pulse seen while busy is low; it is
    // taken on that edge and never queued. The result is valid when
    // track_complete pulses for one cycle, and it then holds until the next start.
    logic                              frame_ready;
    logic [1:0]                        cmd;
    logic [WIN-1:0][WIN-1:0][CW-1:0]   c_frame;
    logic [WIN-1:0][WIN-1:0]           piece_mask;
    logic [CW-1:0]                     piece_color;
    logic [WIN-1:0][WIN-1:0][CW-1:0]   n_frame;
    logic [WIN-1:0][WIN-1:0]           n_mask;
    logic                              rot_ok;
    logic                              track_complete;
    logic                              busy;

    modport master (
        output frame_ready, cmd, c_frame, piece_mask, piece_color,
        input  n_frame, n_mask, rot_ok, track_complete, busy
    );

    modport slave (
        input  frame_ready, cmd, c_frame, piece_mask, piece_color,
        output n_frame, n_mask, rot_ok, track_complete, busy
    );

endinterface

// File: rtl/scan2d.sv
// Row-major cell scanner over a WIN x WIN window; column advances fastest.
module scan2d #(
    parameter int WIN   = 5,
    parameter int CNT_W = $clog2(WIN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_row,
    output logic [CNT_W-1:0] o_col,
    output logic             o_last
);

    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_en) begin
            if (r_col == CNT_W'(WIN - 1)) begin
                r_col <= '0;
                r_row <= (r_row == CNT_W'(WIN - 1)) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == CNT_W'(WIN - 1)) && (r_col == CNT_W'(WIN - 1));

endmodule

// File: rtl/frame_track.sv
// Rotates the active piece inside a captured window, checks it cell by cell
// against locked cells, and builds the updated frame or rejects the move.
module frame_track import frame_pkg::*; #(
    parameter int WIN = WIN_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    frame_track_if.slave        bus,
    output state_t              o_dbg_state
);

    localparam int CNT_W = $clog2(WIN);
    localparam int IDX_W = $clog2(WIN * WIN);

    state_t                          r_state;
    state_t                          w_next;
    logic [WIN-1:0][WIN-1:0][CW-1:0] r_frame;
    logic [WIN-1:0][WIN-1:0][CW-1:0] r_n_frame;
    logic [WIN*WIN-1:0]              r_mask;
    logic [WIN*WIN-1:0]              r_n_mask;
    logic [CW-1:0]                   r_color;
    cmd_t                            r_cmd;
    logic                            r_rot_ok;

    logic [CNT_W-1:0] w_row;
    logic [CNT_W-1:0] w_col;
    logic             w_last;
    logic             w_clr;
    logic             w_en;
    logic [IDX_W-1:0] w_k;
    logic [IDX_W-1:0] w_src;
    logic             w_rot;
    logic             w_cell_mask;
    logic             w_collide;

    scan2d #(.WIN(WIN)) u_scan (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_last (w_last)
    );

    // Rotated-mask bit for the current cell, pulled from the latched mask.
    always_comb begin
        w_k = IDX_W'(int'(w_row) * WIN + int'(w_col));
        case (r_cmd)
            CMD_CW:  w_src = IDX_W'(rot_cw_idx(WIN, int'(w_row), int'(w_col)));
            CMD_CCW: w_src = IDX_W'(rot_ccw_idx(WIN, int'(w_row), int'(w_col)));
            default: w_src = w_k;
        endcase
        w_rot       = r_mask[w_src];
        w_cell_mask = r_mask[w_k];
        w_collide   = w_rot && !w_cell_mask && (r_frame[w_row][w_col] != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_en   = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (bus.frame_ready) w_next = CHECK;
            end
            CHECK: begin
                if (w_collide) begin
                    w_next = DONE;
                end else if (w_last) begin
                    w_next = BUILD;
                    w_clr  = 1'b1;
                end else begin
                    w_en = 1'b1;
                end
            end
            BUILD: begin
                w_en = 1'b1;
                if (w_last) w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame   <= '0;
            r_mask    <= '0;
            r_color   <= '0;
            r_cmd     <= CMD_NONE;
            r_n_frame <= '0;
            r_n_mask  <= '0;
            r_rot_ok  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.frame_ready) begin
                        r_frame <= bus.c_frame;
                        r_mask  <= bus.piece_mask;
                        r_color <= bus.piece_color;
                        r_cmd   <= cmd_t'(bus.cmd);
                    end
                end
                CHECK: begin
                    if (w_collide) begin
                        r_rot_ok  <= 1'b0;
                        r_n_frame <= r_frame;
                        r_n_mask  <= r_mask;
                    end
                end
                BUILD: begin
                    // Old piece cells are vacated unless the rotated piece reoccupies them.
                    r_n_frame[w_row][w_col] <= w_rot ? r_color :
                                               (w_cell_mask ? '0 : r_frame[w_row][w_col]);
                    r_n_mask[w_k] <= w_rot;
                    if (w_last) r_rot_ok <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.n_frame        = r_n_frame;
    assign bus.n_mask         = r_n_mask;
    assign bus.rot_ok         = r_rot_ok;
    assign bus.track_complete = (r_state == DONE);
    assign bus.busy           = (r_state != IDLE);
    assign o_dbg_state        = r_state;

endmodule

// File: doc/frame_track.md
# frame_track

Processing engine on the far side of the 5×5 frame window. It accepts a captured frame of locked cells plus the active-piece mask. It applies a rotation command to the piece, cell by cell, and checks the rotated piece for collisions. It then either builds the updated frame or rejects the move, and pulses `track_complete` so the window writer can commit `n_frame` back into the grid.

## Interface
- `WIN`, 5, frame edge length in cells (≥2)
- `CW`, 3, colour bits per cell; 0 = empty
- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `frame_ready` in 1: start pulse; sampled only in IDLE
- `cmd` in 2: 00 none, 01 rotate CW, 10 rotate CCW, 11 reserved (treated as none)
- `c_frame` in [WIN][WIN][CW]: captured frame, including the piece's own cells
- `piece_mask` in [WIN][WIN]: 1 = cell belongs to the active piece
- `piece_color` in CW: colour written for the rotated piece
- `n_frame` out [WIN][WIN][CW]: updated frame
- `n_mask` out [WIN][WIN]: piece mask after the operation
- `rot_ok` out 1: 1 = move applied, 0 = rejected
- `track_complete` out 1: one-cycle done pulse
- `busy` out 1: high in every state except IDLE

## Operation
- **States:** IDLE → CHECK → BUILD → DONE → IDLE.
- **IDLE:**
  - On `frame_ready`=1, latch `c_frame`, `piece_mask`, `piece_color` and `cmd`.
  - Clear the scan counters (row, col) and go to CHECK.
- **Rotation map** (index arithmetic is CNT_W = $clog2(WIN) bits wide, no wrap):
  - CW: `rot[r][c]` = `mask[WIN-1-c][r]`.
  - CCW: `rot[r][c]` = `mask[c][WIN-1-r]`.
  - none/11: `rot` = `mask`.
- **Scan order:** row-major, col fastest, index k = r·WIN + c. The counter wraps col → 0 and row+1 at col = WIN-1.
- **CHECK:** one cell per cycle.
  - A cell collides when `rot[r][c]` && !`mask[r][c]` && `frame[r][c]` ≠ 0.
  - On the first collision, clear `rot_ok`, copy the latched frame and mask to `n_frame` and `n_mask`, and go to DONE.
  - At the last cell with no collision, go to BUILD with the counters reset to 0.
- **BUILD:** one cell per cycle, `n_frame[r][c]` is set as follows.
  - `piece_color` if `rot[r][c]`.
  - Otherwise 0 if `mask[r][c]`.
  - Otherwise `frame[r][c]`.
  - `n_mask[r][c]` = `rot[r][c]`.
  - After the last cell, set `rot_ok`=1 and go to DONE.
- **DONE:** `track_complete`=1 for exactly this cycle, then return to IDLE.
- **Holding outputs:** `n_frame`, `n_mask` and `rot_ok` hold until the next operation writes them. Partial writes during BUILD are visible on the outputs.
- **Input behaviour:**
  - `frame_ready` while `busy` is ignored; it is not queued.
  - Inputs may change after the start edge without effect.
- **Reset:** `rst` at any time, including mid-CHECK or mid-BUILD, forces IDLE. All outputs and the counters go to 0 and the operation is abandoned with no done pulse.

## Timing
- **Reset values:** `n_frame`=0, `n_mask`=0, `rot_ok`=0, `track_complete`=0, `busy`=0.
- **Start edge:** E0 is the edge that samples `frame_ready`. `busy` rises after E0.
- **Accepted move:** `track_complete` is high in the cycle after edge E(2·WIN²), i.e. E50 for WIN=5. `n_frame` is final at that point.
- **Collision at scan index k:** `track_complete` is high after E(k+1).
- **Back-to-back:** `busy` falls with the exit from DONE. The earliest next start is sampled on the edge ending the first IDLE cycle.
- **Output decode:** `track_complete` and `busy` are decoded from the registered state with no combinational input path.

## Structure
- **Package `frame_pkg`:**
  - `state_t` {IDLE, CHECK, BUILD, DONE}.
  - `cmd_t` {CMD_NONE, CMD_CW, CMD_CCW, CMD_RSV}.
  - Default WIN and CW constants.
  - Rotation index functions `rot_cw_idx` and `rot_ccw_idx`.
- **Sub-module `scan2d`:**
  - Row/col counter with `clr`, `en` and `last` outputs.
  - Parameterised by WIN.
  - Shared with the window writer.

## Test plan
- **Accepted CW rotation:** mask (0..3,2), colour 5, empty frame, cmd 01.
  - Row 2 cols 1–4 = 5, all other cells 0.
  - `rot_ok`=1, `track_complete` after E50.
- **Collision rejected:** same stimulus plus `c_frame[2][4]`=1.
  - Collision at k=14, `track_complete` after E15.
  - `rot_ok`=0, `n_frame` equals the input frame, `n_mask` equals the input mask.
- **Accepted CCW rotation:** same mask, cmd 10.
  - Row 2 cols 0–3 = 5, column 2 rows 0,1,3 cleared.
- **Reserved cmd 11 with locked cells:** cmd 11 with `c_frame[4][4]`=7.
  - `n_frame` equals the input frame with the piece cells recoloured.
  - `rot_ok`=1.
- **`frame_ready` while busy:** pulse `frame_ready` at E10 of a running operation.
  - Exactly one `track_complete`, at E50.
- **Reset mid-BUILD:** assert `rst` at E30.
  - All outputs 0 immediately.
  - No `track_complete`.
  - A new start then completes normally.
